// File: rtl/dma_pkg.sv
// Shared constants and helpers for the DMA burst engine.
package dma_pkg;

    // FSM state encodings
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StRaddr = 3'd2;
    localparam logic [2:0] StRdata = 3'd3;
    localparam logic [2:0] StWaddr = 3'd4;
    localparam logic [2:0] StWdata = 3'd5;
    localparam logic [2:0] StWresp = 3'd6;
    localparam logic [2:0] StDone  = 3'd7;

    // AXI encodings
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_STRB_ALL   = 4'hF;

    // Legal burst limits: power of two in 2..16 (AXI3 4-bit LEN)
    function automatic bit burst_max_valid(input int unsigned n);
        return (n >= 2) && (n <= 16) && ((n & (n - 1)) == 0);
    endfunction

    // Beats for the next burst: min(remaining, limit)
    function automatic logic [31:0] burst_beats(input logic [31:0] rem,
                                                input logic [31:0] max);
        return (rem < max) ? rem : max;
    endfunction

endpackage

// File: rtl/dma_burst_fifo.sv
// First-word fall-through FIFO holding one read burst until it is written out.
module dma_burst_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
        if (push && !pop) count_d = count_q + cnt_t'(1);
        if (pop && !push) count_d = count_q - cnt_t'(1);
    end

    // Pointer state; reset empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy gates validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == cnt_t'(DEPTH));

endmodule

// File: rtl/dma_burst_engine.sv
// Single-channel AXI DMA: read a burst into the FIFO, write it back out, repeat.
module dma_burst_engine
    import dma_pkg::*;
#(
    parameter int unsigned BURST_MAX = 16,
    parameter logic [3:0]  AXI_ID    = 4'b0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DMAEN,
    input  logic [31:0] DMASRC,
    input  logic [31:0] DMADST,
    input  logic [31:0] DMALEN,
    output logic        DMA_interrupt,
    output logic        DMA_err,
    output logic        DMA_busy,
    output logic [3:0]  M_ARID,
    output logic [31:0] M_ARADDR,
    output logic [3:0]  M_ARLEN,
    output logic [2:0]  M_ARSIZE,
    output logic [1:0]  M_ARBURST,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [3:0]  M_RID,
    input  logic [31:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RLAST,
    input  logic        M_RVALID,
    output logic        M_RREADY,
    output logic [3:0]  M_AWID,
    output logic [31:0] M_AWADDR,
    output logic [3:0]  M_AWLEN,
    output logic [2:0]  M_AWSIZE,
    output logic [1:0]  M_AWBURST,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_WSTRB,
    output logic        M_WLAST,
    output logic        M_WVALID,
    input  logic        M_WREADY,
    input  logic [3:0]  M_BID,
    input  logic [1:0]  M_BRESP,
    input  logic        M_BVALID,
    output logic        M_BREADY
);

    if (!burst_max_valid(BURST_MAX)) begin : g_bad_burst_max
        $error("BURST_MAX must be a power of two in 2..16");
    end

    localparam int unsigned BW = $clog2(BURST_MAX) + 1;
    typedef logic [BW-1:0] beats_t;

    logic [2:0]  state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] rem_q, rem_d;
    beats_t      beats_q, beats_d;
    beats_t      cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;

    logic        busy;
    logic        wlast;
    logic [31:0] rem_next;
    logic [31:0] burst_bytes;
    logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [31:0] fifo_dout;
    logic        unused_ids;

    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign wlast       = (cnt_q == beats_q - beats_t'(1));
    assign rem_next    = rem_q - 32'(beats_q);
    assign burst_bytes = 32'(beats_q) << 2;
    assign unused_ids  = ^{M_RID, M_BID};

    // Guards are redundant by construction (one burst fits exactly)
    assign fifo_push = (state_q == StRdata) && M_RVALID && !fifo_full;
    assign fifo_pop  = (state_q == StWdata) && M_WREADY && !fifo_empty;

    dma_burst_fifo #(
        .DEPTH (BURST_MAX),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (M_RDATA),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // FSM next-state, address/length bookkeeping and sticky error/abort flags
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        beats_d = beats_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        abort_d = abort_q | (busy & ~DMAEN);

        case (state_q)
            StIdle: begin
                if (DMAEN) begin
                    state_d = StLoad;
                    src_d   = DMASRC;
                    dst_d   = DMADST;
                    rem_d   = DMALEN;
                end
            end
            StLoad: begin
                // No burst has started yet, so an abort can finish right away
                if (rem_q == 32'd0 || abort_d) begin
                    state_d = StDone;
                end else begin
                    state_d = StRaddr;
                    beats_d = beats_t'(burst_beats(rem_q, 32'(BURST_MAX)));
                end
            end
            StRaddr: begin
                if (M_ARREADY) state_d = StRdata;
            end
            StRdata: begin
                if (M_RVALID) begin
                    if (M_RRESP != AXI_RESP_OKAY) err_d = 1'b1;
                    if (M_RLAST) state_d = StWaddr;
                end
            end
            StWaddr: begin
                if (M_AWREADY) begin
                    state_d = StWdata;
                    cnt_d   = '0;
                end
            end
            StWdata: begin
                if (M_WREADY) begin
                    cnt_d = cnt_q + beats_t'(1);
                    if (wlast) state_d = StWresp;
                end
            end
            StWresp: begin
                if (M_BVALID) begin
                    if (M_BRESP != AXI_RESP_OKAY) err_d = 1'b1;
                    src_d = src_q + burst_bytes;
                    dst_d = dst_q + burst_bytes;
                    rem_d = rem_next;
                    if (rem_next == 32'd0 || err_d || abort_d) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRaddr;
                        beats_d = beats_t'(burst_beats(rem_next, 32'(BURST_MAX)));
                    end
                end
            end
            StDone: begin
                if (!DMAEN) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Engine state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    assign DMA_interrupt = (state_q == StDone) && !abort_q;
    assign DMA_err       = (state_q == StDone) && err_q;
    assign DMA_busy      = busy;

    assign M_ARID    = AXI_ID;
    assign M_ARADDR  = src_q;
    assign M_ARLEN   = 4'(beats_q - beats_t'(1));
    assign M_ARSIZE  = AXI_SIZE_4B;
    assign M_ARBURST = AXI_BURST_INCR;
    assign M_ARVALID = (state_q == StRaddr);
    assign M_RREADY  = (state_q == StRdata);

    assign M_AWID    = AXI_ID;
    assign M_AWADDR  = dst_q;
    assign M_AWLEN   = 4'(beats_q - beats_t'(1));
    assign M_AWSIZE  = AXI_SIZE_4B;
    assign M_AWBURST = AXI_BURST_INCR;
    assign M_AWVALID = (state_q == StWaddr);

    assign M_WDATA   = fifo_dout;
    assign M_WSTRB   = AXI_STRB_ALL;
    assign M_WLAST   = (state_q == StWdata) && wlast;
    assign M_WVALID  = (state_q == StWdata);
    assign M_BREADY  = (state_q == StWresp);

endmodule
